tqvp_crc_multi: RTL and testbench

- Parametrised CRC peripheral on the TinyQV peripheral bus; successor to the fixed CRC-32 byte engine.
- Supports runtime CRC width (8/16/32), programmable poly/init/xorout and input/output reflection.
- Packs 8/16/32-bit bus writes into a byte FIFO and drains it through a bit-serial engine.
- Raises a completion interrupt when the FIFO fully drains.

---
 rtl/tqvp_crc_multi.sv | 213 +++++++++++++++++++++
 tb/tb_tqvp_crc_multi.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_crc_multi.sv
// rtl/tqvp_crc_multi.sv - runtime-configurable CRC-8/16/32 peripheral with byte FIFO and bit-serial engine
module tqvp_crc_multi #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_POLY   = 6'h04;
    localparam logic [5:0] A_INIT   = 6'h08;
    localparam logic [5:0] A_XOR    = 6'h0C;
    localparam logic [5:0] A_DATA   = 6'h10;
    localparam logic [5:0] A_RESULT = 6'h14;
    localparam logic [5:0] A_STATUS = 6'h18;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic [31:0]      poly_q, poly_d, init_q, init_d, xor_q, xor_d, crc_q, crc_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, irq_q, irq_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic             wr_en, restart, push, pop, busy, busy_next, fb, in_bit;
    logic [31:0]      wr_mask, w_mask, crc_step, crc_rev, result, status;
    logic [2:0]       wr_bytes;
    logic [4:0]       rev_shift;
    logic [CNT_W:0]   free_slots;
    logic             unused_ok;

    assign unused_ok = &{1'b0, ui_in, data_read_n};

    always_comb begin
        wr_mask  = 32'hFFFF_FFFF;
        wr_bytes = 3'd4;
        case (data_write_n)
            2'b00: begin wr_mask = 32'h0000_00FF; wr_bytes = 3'd1; end
            2'b01: begin wr_mask = 32'h0000_FFFF; wr_bytes = 3'd2; end
            default: ;
        endcase
    end

    // ctrl[3:2]: 00 -> 8 bit, 01 -> 16 bit, 1x -> 32 bit
    always_comb begin
        w_mask    = 32'h0000_00FF;
        rev_shift = 5'd24;
        fb        = crc_q[7];
        if (ctrl_q[3]) begin
            w_mask    = 32'hFFFF_FFFF;
            rev_shift = 5'd0;
            fb        = crc_q[31];
        end else if (ctrl_q[2]) begin
            w_mask    = 32'h0000_FFFF;
            rev_shift = 5'd16;
            fb        = crc_q[15];
        end
    end

    assign in_bit   = ctrl_q[0] ? byte_q[bit_q] : byte_q[3'd7 - bit_q];
    assign crc_step = ((crc_q << 1) ^ ((fb ^ in_bit) ? poly_q : 32'h0)) & w_mask;

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++) crc_rev[i] = crc_q[31 - i];
    end

    assign result = ((ctrl_q[1] ? (crc_rev >> rev_shift) : crc_q) ^ xor_q) & w_mask;

    assign wr_en      = (data_write_n != 2'b11);
    assign busy       = (state_q == ST_SHIFT) || (count_q != '0);
    assign free_slots = DEPTH_C - {1'b0, count_q};
    assign restart    = wr_en && (address == A_CTRL) && data_in[7];
    assign push       = wr_en && (address == A_DATA) && (free_slots >= (CNT_W + 1)'(wr_bytes));
    assign pop        = (state_q == ST_IDLE) && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        poly_d   = poly_q;
        init_d   = init_q;
        xor_d    = xor_q;
        crc_d    = crc_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        irq_d    = irq_q;

        if (wr_en && !busy) begin
            case (address)
                A_CTRL: ctrl_d = data_in[4:0];
                A_POLY: poly_d = (poly_q & ~wr_mask) | (data_in & wr_mask);
                A_INIT: init_d = (init_q & ~wr_mask) | (data_in & wr_mask);
                A_XOR:  xor_d  = (xor_q & ~wr_mask) | (data_in & wr_mask);
                default: ;
            endcase
        end
        if (wr_en && (address == A_STATUS)) begin
            if (data_in[9] && wr_mask[9])   ovf_d = 1'b0;
            if (data_in[10] && wr_mask[10]) irq_d = 1'b0;
        end
        if (wr_en && (address == A_DATA) && !push) ovf_d = 1'b1;

        if (pop) begin
            byte_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            bit_d    = 3'd0;
            state_d  = ST_SHIFT;
        end else if (state_q == ST_SHIFT) begin
            crc_d = crc_step;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_IDLE;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(wr_bytes);
        count_d = count_q + (push ? CNT_W'(wr_bytes) : '0) - CNT_W'(pop);

        if (restart) begin
            ctrl_d   = data_in[4:0];
            state_d  = ST_IDLE;
            crc_d    = init_q;
            bit_d    = 3'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        // completion edge of busy; set wins over a same-cycle software clear
        busy_next = (state_d == ST_SHIFT) || (count_d != '0);
        if (busy && !busy_next && !restart && ctrl_q[4]) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 5'h0B;
            poly_q   <= 32'h04C1_1DB7;
            init_q   <= 32'hFFFF_FFFF;
            xor_q    <= 32'hFFFF_FFFF;
            crc_q    <= 32'hFFFF_FFFF;
            byte_q   <= '0;
            bit_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            poly_q   <= poly_d;
            init_q   <= init_d;
            xor_q    <= xor_d;
            crc_q    <= crc_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    // data_in[7:0] lands first so multi-byte writes are little-endian in the FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(wr_bytes)) mem_q[wr_ptr_q + PTR_W'(k)] <= data_in[8*k +: 8];
            end
        end
    end

    always_comb begin
        status                = '0;
        status[CNT_W-1:0]     = count_q;
        status[8]             = busy;
        status[9]             = ovf_q;
        status[10]            = irq_q;
        data_out              = '0;
        case (address)
            A_CTRL:   data_out = {27'b0, ctrl_q};
            A_POLY:   data_out = poly_q;
            A_INIT:   data_out = init_q;
            A_XOR:    data_out = xor_q;
            A_RESULT: data_out = result;
            A_STATUS: data_out = status;
            default:  ;
        endcase
    end

    assign data_ready     = !((address == A_RESULT) && busy);
    assign user_interrupt = irq_q;
    assign uo_out         = {5'b0, irq_q, busy, 1'b0};

endmodule

// File: tb/tb_tqvp_crc_multi.sv
// tb/tb_tqvp_crc_multi.sv - self-checking bench for tqvp_crc_multi
module tb_tqvp_crc_multi;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam logic [5:0] A_CTRL = 6'h00, A_POLY = 6'h04, A_INIT = 6'h08, A_XOR = 6'h0C;
    localparam logic [5:0] A_DATA = 6'h10, A_RESULT = 6'h14, A_STATUS = 6'h18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int n_cmp = 0;
    int n_fail = 0;

    tqvp_crc_multi #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Byte-at-a-time CRC; reflected-input variant uses the right-shifting form
    function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly, input logic [31:0] init,
                                              input logic [31:0] xo, input bit refin, input bit refout,
                                              input logic [7:0] q[$]);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        logic [31:0] r, rp, crc;
        if (refin) begin
            r  = reflect(init & mask, w);
            rp = reflect(poly & mask, w);
            foreach (q[j]) begin
                r = r ^ {24'h0, q[j]};
                for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
            end
            crc = reflect(r, w);
        end else begin
            r = init & mask;
            foreach (q[j]) begin
                r = r ^ ({24'h0, q[j]} << (w - 8));
                for (int b = 0; b < 8; b++) r = r[w-1] ? (((r << 1) ^ poly) & mask) : ((r << 1) & mask);
            end
            crc = r;
        end
        return ((refout ? reflect(crc, w) : crc) ^ xo) & mask;
    endfunction

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        address = a; data_in = d; data_write_n = sz;
        @(posedge clk);
        #1 data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = 2'b10;
        #1 d = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        int n = 0;
        bus_read(A_STATUS, st);
        while (st[8] && n < 2000) begin
            bus_read(A_STATUS, st);
            n++;
        end
        n_cmp++;
        if (st[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b required 0", tag, st[8]);
        end
    endtask

    task automatic configure(input logic [1:0] wc, input bit ri, input bit ro, input bit ie,
                             input logic [31:0] p, input logic [31:0] i0, input logic [31:0] x);
        bus_write(A_POLY, p, 2'b10);
        bus_write(A_INIT, i0, 2'b10);
        bus_write(A_XOR, x, 2'b10);
        bus_write(A_CTRL, {24'h0, 1'b1, 2'b00, ie, wc, ro, ri}, 2'b00);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus_read(A_CTRL, v);
        n_cmp++; if (v !== 32'h0B) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0000000b", v); end
        bus_read(A_POLY, v);
        n_cmp++; if (v !== 32'h04C11DB7) begin n_fail++; $display("FAIL reset_poly: got %h required 04c11db7", v); end
        bus_read(A_INIT, v);
        n_cmp++; if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_init: got %h required ffffffff", v); end
        bus_read(A_XOR, v);
        n_cmp++; if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_xorout: got %h required ffffffff", v); end
        bus_read(A_STATUS, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h required 00000000", v); end
        bus_read(A_RESULT, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h required 00000000", v); end
        n_cmp++;
        if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: uo_out=%h irq=%b ready=%b required 00 0 1", uo_out, user_interrupt, data_ready);
        end
    endtask

    task automatic test_crc32_check();
        logic [31:0] v;
        string s = "123456789";
        for (int i = 0; i < 9; i++) bus_write(A_DATA, {24'h0, s[i]}, 2'b00);
        wait_idle("crc32");
        bus_read(A_RESULT, v);
        n_cmp++; if (v !== 32'hCBF43926) begin n_fail++; $display("FAIL crc32_result: got %h required cbf43926", v); end
        bus_read(A_STATUS, v);
        n_cmp++; if (v[CW-1:0] !== 4'd0 || v[9] !== 1'b0) begin n_fail++; $display("FAIL crc32_status: got %h required count 0 no overflow", v); end
    endtask

    task automatic test_crc16();
        logic [31:0] v;
        bus_write(A_CTRL, 32'h84, 2'b00);
        configure(2'b01, 1'b0, 1'b0, 1'b0, 32'h1021, 32'hFFFF, 32'h0);
        bus_write(A_DATA, 32'h34333231, 2'b10);
        bus_write(A_DATA, 32'h38373635, 2'b10);
        bus_write(A_DATA, 32'h39, 2'b00);
        wait_idle("crc16");
        bus_read(A_RESULT, v);
        n_cmp++; if (v !== 32'h000029B1) begin n_fail++; $display("FAIL crc16_result: got %h required 000029b1", v); end
    endtask

    task automatic test_crc8_stall();
        string s = "123456789";
        int n = 0;
        configure(2'b00, 1'b0, 1'b0, 1'b0, 32'h07, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(A_DATA, {24'h0, s[i]}, 2'b00);
        @(negedge clk);
        address = A_RESULT; data_read_n = 2'b10;
        #1;
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL crc8_stall: data_ready=%b required 0", data_ready); end
        while (data_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (data_ready !== 1'b1 || data_out !== 32'hF4 || uo_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL crc8_result: ready=%b data=%h busy=%b required 1 000000f4 0", data_ready, data_out, uo_out[1]);
        end
        data_read_n = 2'b11;
    endtask

    task automatic test_overflow();
        logic [31:0] v, w0, w1, w2;
        logic [7:0] q[$];
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        configure(2'b10, 1'b1, 1'b1, 1'b0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bus_write(A_DATA, w0, 2'b10);
        bus_write(A_DATA, w1, 2'b10);
        bus_write(A_DATA, w2, 2'b10);
        bus_read(A_STATUS, v);
        n_cmp++;
        if (v[CW-1:0] !== 4'd7 || v[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drop: count=%0d ovf=%b required 7 1", v[CW-1:0], v[9]);
        end
        wait_idle("overflow");
        for (int i = 0; i < 4; i++) q.push_back(w0[8*i +: 8]);
        for (int i = 0; i < 4; i++) q.push_back(w1[8*i +: 8]);
        bus_read(A_RESULT, v);
        n_cmp++;
        if (v !== model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, q)) begin
            n_fail++;
            $display("FAIL overflow_result: got %h required %h", v, model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, q));
        end
        bus_write(A_STATUS, 32'h200, 2'b10);
        bus_read(A_STATUS, v);
        n_cmp++; if (v[9] !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: ovf=%b required 0", v[9]); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        logic [7:0] q[$];
        int first = 0;
        configure(2'b10, 1'b1, 1'b1, 1'b1, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_cmp++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_idle: irq=%b required 0", user_interrupt); end
        bus_write(A_DATA, 32'hA5, 2'b00);
        bus_write(A_POLY, 32'h12345678, 2'b10);
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (user_interrupt === 1'b1 && first == 0) first = c;
        end
        n_cmp++; if (first != 9) begin n_fail++; $display("FAIL irq_latency: rose after %0d cycles required 9", first); end
        bus_read(A_POLY, v);
        n_cmp++; if (v !== 32'h04C11DB7) begin n_fail++; $display("FAIL irq_poly_locked: got %h required 04c11db7", v); end
        q.push_back(8'hA5);
        bus_read(A_RESULT, v);
        n_cmp++;
        if (v !== model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, q)) begin
            n_fail++;
            $display("FAIL irq_result: got %h required %h", v, model_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, q));
        end
        bus_read(A_STATUS, v);
        n_cmp++; if (v[10] !== 1'b1 || uo_out[2] !== 1'b1) begin n_fail++; $display("FAIL irq_status: pending=%b uo2=%b required 1 1", v[10], uo_out[2]); end
        bus_write(A_STATUS, 32'h400, 2'b10);
        n_cmp++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b required 0", user_interrupt); end
    endtask

    task automatic test_random();
        logic [31:0] v, p, i0, x, d;
        logic [7:0] q[$];
        int w, len, idx, nb, guard;
        bit ri, ro;
        logic [1:0] wc;
        for (int it = 0; it < 8; it++) begin
            wc = 2'($urandom_range(0, 2));
            w  = 8 << wc;
            ri = 1'($urandom); ro = 1'($urandom);
            p = $urandom | 32'h1; i0 = $urandom; x = $urandom;
            configure(wc, ri, ro, 1'b0, p, i0, x);
            len = $urandom_range(1, 12);
            q.delete();
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            idx = 0; guard = 0;
            while (idx < len && guard < 1000) begin
                guard++;
                bus_read(A_STATUS, v);
                if (v[CW-1:0] <= 4'(DEPTH - 4)) begin
                    nb = 1 << $urandom_range(0, 2);
                    while (nb > len - idx) nb = nb >> 1;
                    d = '0;
                    for (int k = 0; k < nb; k++) d[8*k +: 8] = q[idx + k];
                    bus_write(A_DATA, d, (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b10);
                    idx += nb;
                end
            end
            wait_idle("random");
            bus_read(A_RESULT, v);
            n_cmp++;
            if (v !== model_crc(w, p, i0, x, ri, ro, q) || idx != len) begin
                n_fail++;
                $display("FAIL random_%0d: w=%0d got %h required %h", it, w, v, model_crc(w, p, i0, x, ri, ro, q));
            end
        end
        bus_read(A_STATUS, v);
        n_cmp++; if (v[9] !== 1'b0) begin n_fail++; $display("FAIL random_no_overflow: ovf=%b required 0", v[9]); end
    endtask

    task automatic test_restart();
        logic [31:0] v;
        logic [7:0] q[$];
        configure(2'b10, 1'b1, 1'b1, 1'b1, 32'h04C11DB7, 32'h12345678, 32'hFFFFFFFF);
        bus_write(A_DATA, $urandom, 2'b10);
        @(posedge clk);
        bus_write(A_CTRL, 32'h9B, 2'b00);
        bus_read(A_STATUS, v);
        n_cmp++; if (v[CW-1:0] !== 4'd0 || v[8] !== 1'b0) begin n_fail++; $display("FAIL restart_flush: count=%0d busy=%b required 0 0", v[CW-1:0], v[8]); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL restart_no_irq: irq=%b required 0", user_interrupt); end
        bus_read(A_RESULT, v);
        n_cmp++;
        if (v !== model_crc(32, 32'h04C11DB7, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, q)) begin
            n_fail++;
            $display("FAIL restart_result: got %h required %h", v, model_crc(32, 32'h04C11DB7, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, q));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(A_CTRL, 32'h80, 2'b00);
        bus_write(A_DATA, $urandom, 2'b10);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        test_reset();
        bus_read(A_STATUS, v);
        n_cmp++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mid_status: got %h required 00000000", v); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_crc32_check();
        test_crc16();
        test_crc8_stall();
        test_overflow();
        test_irq();
        bus_write(A_STATUS, 32'h600, 2'b10);
        test_random();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
